// File: rtl/ldpc_enc_pkg.sv
// ldpc_enc shared definitions: rates, code sizes,
// FSM states and generator-row table seeds.
package ldpc_enc_pkg;

  localparam logic RATE_12 = 1'b0;
  localparam logic RATE_34 = 1'b1;

  localparam int N_LEN = 96;
  localparam int K_R12 = 48;
  localparam int K_R34 = 72;
  localparam int M_R12 = N_LEN - K_R12;
  localparam int M_R34 = N_LEN - K_R34;
  localparam int M_MAX = M_R12;

  localparam logic [6:0] K12_LAST = 7'(K_R12 - 1);
  localparam logic [6:0] K34_LAST = 7'(K_R34 - 1);
  localparam logic [6:0] M12_LAST = 7'(M_R12 - 1);
  localparam logic [6:0] M34_LAST = 7'(M_R34 - 1);

  // Row i of table r is the seed rotated left by
  // (i mod 48) with the index XORed into the low bits.
  localparam logic [M_MAX-1:0] G_SEED [2] = '{
    48'hA5C3_96F0_1E2D,
    48'h3C6E_B1D4_8A97
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INFO   = 2'd1,
    PARITY = 2'd2
  } state_e;

endpackage

// File: rtl/ldpc_enc_grom.sv
// ldpc_enc generator-row lookup.
// Pure combinational (rate, index) -> row.
import ldpc_enc_pkg::*;

module ldpc_enc_grom (
  input  logic             rate_i,
  input  logic [6:0]       idx_i,
  output logic [M_MAX-1:0] row_o
);

  logic [6:0]         rot;
  logic [2*M_MAX-1:0] dbl;
  logic [M_MAX-1:0]   seed;

  // Rotate the table seed and fold in the index;
  // rate 3/4 rows keep only the low 24 bits.
  always_comb begin
    seed = G_SEED[rate_i];
    rot  = (idx_i >= 7'd48) ? idx_i - 7'd48 : idx_i;
    dbl  = {seed, seed} << rot;
    row_o = dbl[2*M_MAX-1:M_MAX] ^ {41'd0, idx_i};
    if (rate_i == RATE_34)
      row_o[M_MAX-1:M_R34] = '0;
  end

endmodule

// File: rtl/ldpc_enc.sv
// ldpc_enc: bit-serial systematic LDPC encoder.
// Info bits echoed, parity accumulated then shifted out.
import ldpc_enc_pkg::*;

module ldpc_enc (
  input  logic clk,
  input  logic reset,
  input  logic code_rate,
  input  logic data_in,
  input  logic sync_in,
  output logic data_out,
  output logic sync_out,
  output logic valid_out,
  output logic busy,
  output logic sync_err
);

  state_e           state_q;
  logic [6:0]       cnt_q;
  logic [M_MAX-1:0] p_q;
  logic             rate_q;
  logic             data_q;
  logic             sync_q;
  logic             valid_q;
  logic             busy_q;
  logic             err_q;

  logic [6:0]       k_last;
  logic [6:0]       m_last;
  logic             par_end;
  logic             accept;
  logic             rom_rate;
  logic [6:0]       rom_idx;
  logic [M_MAX-1:0] row;
  logic [M_MAX-1:0] row_g;

  // Block sizes, acceptance window and ROM address.
  // INFO at count c samples info bit c+1; the
  // accepted sync cycle itself samples bit 0.
  always_comb begin
    k_last   = rate_q ? K34_LAST : K12_LAST;
    m_last   = rate_q ? M34_LAST : M12_LAST;
    par_end  = (state_q == PARITY) && (cnt_q == m_last);
    accept   = sync_in && ((state_q == IDLE) || par_end);
    rom_rate = accept ? code_rate : rate_q;
    rom_idx  = accept ? 7'd0 : cnt_q + 7'd1;
    row_g    = data_in ? row : '0;
  end

  ldpc_enc_grom u_grom (
    .rate_i (rom_rate),
    .idx_i  (rom_idx),
    .row_o  (row)
  );

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      rate_q  <= 1'b0;
      data_q  <= 1'b0;
      sync_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q   <= sync_in && !accept;
      sync_q  <= accept;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      if (accept) begin
        state_q <= INFO;
        cnt_q   <= '0;
        rate_q  <= code_rate;
        p_q     <= row_g;
        data_q  <= data_in;
        valid_q <= 1'b1;
        busy_q  <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            busy_q <= 1'b0;
          end
          INFO: begin
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            if (cnt_q == k_last) begin
              data_q  <= p_q[0];
              p_q     <= p_q >> 1;
              cnt_q   <= '0;
              state_q <= PARITY;
            end else begin
              data_q <= data_in;
              p_q    <= p_q ^ row_g;
              cnt_q  <= cnt_q + 7'd1;
            end
          end
          PARITY: begin
            if (cnt_q == m_last) begin
              busy_q  <= 1'b0;
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              data_q  <= p_q[0];
              p_q     <= p_q >> 1;
              cnt_q   <= cnt_q + 7'd1;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out  = data_q;
  assign sync_out  = sync_q;
  assign valid_out = valid_q;
  assign busy      = busy_q;
  assign sync_err  = err_q;

endmodule

// File: tb/tb_ldpc_enc.sv
// tb_ldpc_enc: directed bench for ldpc_enc.
// Captures outputs per cycle, checks against a golden model.
module tb_ldpc_enc;

  localparam logic [47:0] SEED0 = 48'hA5C3_96F0_1E2D;
  localparam logic [47:0] SEED1 = 48'h3C6E_B1D4_8A97;
  localparam logic [47:0] G00   = 48'hA5C3_96F0_1E2D;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic code_rate = 1'b0;
  logic data_in = 1'b0;
  logic sync_in = 1'b0;
  logic data_out, sync_out, valid_out, busy, sync_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic cap_d [0:4095];
  logic cap_s [0:4095];
  logic cap_v [0:4095];
  logic cap_b [0:4095];
  logic cap_e [0:4095];

  ldpc_enc dut (
    .clk       (clk),
    .reset     (reset),
    .code_rate (code_rate),
    .data_in   (data_in),
    .sync_in   (sync_in),
    .data_out  (data_out),
    .sync_out  (sync_out),
    .valid_out (valid_out),
    .busy      (busy),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int at,
                     input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc %0d: got %b expected %b",
             tag, at, obs, exp);
    end
  endtask

  // Inputs for cycle cyc; outputs of cycle cyc+1 captured.
  task automatic step(input logic d, input logic s,
                      input logic r);
    data_in = d;
    sync_in = s;
    code_rate = r;
    @(posedge clk);
    #1;
    cyc++;
    cap_d[cyc] = data_out;
    cap_s[cyc] = sync_out;
    cap_v[cyc] = valid_out;
    cap_b[cyc] = busy;
    cap_e[cyc] = sync_err;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive(input logic r, input logic [71:0] info,
                       input int n, input int extra);
    for (int i = 0; i < n; i++)
      step(info[i], (i == 0) || (i == extra), r);
  endtask

  function automatic logic [47:0] brow(input logic r,
                                       input int i);
    logic [47:0] c;
    logic [47:0] row;
    logic [7:0] ib;
    int sh;
    c = r ? SEED1 : SEED0;
    sh = i % 48;
    ib = 8'(i);
    for (int b = 0; b < 48; b++)
      row[b] = c[(b - sh + 48) % 48];
    row[7:0] = row[7:0] ^ ib;
    if (r) row[47:24] = '0;
    return row;
  endfunction

  function automatic logic [47:0] golden(input logic r,
                                         input logic [71:0] info);
    logic [47:0] p;
    int k;
    k = r ? 72 : 48;
    p = '0;
    for (int i = 0; i < k; i++)
      if (info[i]) p = p ^ brow(r, i);
    return p;
  endfunction

  // Whole codeword starting at sync cycle s.
  task automatic check_cw(input string tag, input int s,
                          input logic r, input logic [71:0] info);
    logic [47:0] par;
    logic exp;
    int k;
    k = r ? 72 : 48;
    par = golden(r, info);
    for (int o = 1; o <= 96; o++) begin
      exp = (o <= k) ? info[o-1] : par[o-k-1];
      chk({tag, ".data"}, s + o, cap_d[s+o], exp);
      chk({tag, ".valid"}, s + o, cap_v[s+o], 1'b1);
      chk({tag, ".sync"}, s + o, cap_s[s+o], o == 1);
    end
  endtask

  initial begin
    int s, s2;
    logic [71:0] pat;

    // Reset state
    idle(2);
    chk("rst.data", cyc, cap_d[cyc], 1'b0);
    chk("rst.sync", cyc, cap_s[cyc], 1'b0);
    chk("rst.valid", cyc, cap_v[cyc], 1'b0);
    chk("rst.busy", cyc, cap_b[cyc], 1'b0);
    chk("rst.err", cyc, cap_e[cyc], 1'b0);
    reset = 1'b0;
    idle(2);

    // 1: rate 1/2, all zeros
    s = cyc;
    drive(1'b0, 72'd0, 48, -1);
    idle(52);
    check_cw("t1", s, 1'b0, 72'd0);
    chk("t1.busy_first", s + 1, cap_b[s+1], 1'b1);
    chk("t1.busy_last", s + 96, cap_b[s+96], 1'b1);
    chk("t1.busy_fall", s + 97, cap_b[s+97], 1'b0);
    chk("t1.valid_end", s + 97, cap_v[s+97], 1'b0);
    chk("t1.data_end", s + 97, cap_d[s+97], 1'b0);

    // 2: rate 1/2, single one at index 0
    s = cyc;
    drive(1'b0, 72'd1, 48, -1);
    idle(52);
    check_cw("t2", s, 1'b0, 72'd1);
    for (int j = 0; j < 48; j++)
      chk("t2.g00", s + 49 + j, cap_d[s+49+j], G00[j]);

    // 3: rate 3/4, fixed pattern
    pat = 72'hC3_5A69_0F1E_D2B4_8796;
    s = cyc;
    drive(1'b1, pat, 72, -1);
    idle(28);
    check_cw("t3", s, 1'b1, pat);
    chk("t3.valid_end", s + 97, cap_v[s+97], 1'b0);
    chk("t3.data_end", s + 97, cap_d[s+97], 1'b0);

    // 4: back-to-back, rate 1/2 then rate 3/4
    pat = 72'h00_F0F0_1234_ABCD_5A5A;
    s = cyc;
    drive(1'b0, pat, 48, -1);
    idle(48);
    s2 = cyc;
    drive(1'b1, ~pat, 72, -1);
    idle(28);
    chk("t4.gap", s2, 1'(s2 - s), 1'b0);
    check_cw("t4a", s, 1'b0, pat);
    check_cw("t4b", s2, 1'b1, ~pat);
    chk("t4.sync2", s + 97, cap_s[s+97], 1'b1);
    for (int o = 1; o <= 192; o++) begin
      chk("t4.valid", s + o, cap_v[s+o], 1'b1);
      chk("t4.busy", s + o, cap_b[s+o], 1'b1);
      chk("t4.err", s + o, cap_e[s+o], 1'b0);
    end
    chk("t4.valid_end", s + 193, cap_v[s+193], 1'b0);

    // 5: stray sync_in at info index 10
    pat = 72'h00_1357_9BDF_2468_ACE0;
    s = cyc;
    drive(1'b0, pat, 48, 10);
    idle(52);
    chk("t5.err_pre", s + 10, cap_e[s+10], 1'b0);
    chk("t5.err", s + 11, cap_e[s+11], 1'b1);
    chk("t5.err_post", s + 12, cap_e[s+12], 1'b0);
    check_cw("t5", s, 1'b0, pat);
    chk("t5.valid_end", s + 97, cap_v[s+97], 1'b0);

    // 6: reset at info index 20, then clean block
    s = cyc;
    drive(1'b0, {72{1'b1}}, 20, -1);
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    chk("t6.data", s + 21, cap_d[s+21], 1'b0);
    chk("t6.sync", s + 21, cap_s[s+21], 1'b0);
    chk("t6.valid", s + 21, cap_v[s+21], 1'b0);
    chk("t6.busy", s + 21, cap_b[s+21], 1'b0);
    chk("t6.err", s + 21, cap_e[s+21], 1'b0);
    idle(3);
    chk("t6.quiet", cyc, cap_v[cyc], 1'b0);
    pat = 72'h00_0000_8000_0000_0003;
    s = cyc;
    drive(1'b0, pat, 48, -1);
    idle(52);
    check_cw("t6", s, 1'b0, pat);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ldpc_enc.md
Name: ldpc_enc

Overview:
Bit-serial systematic LDPC encoder, the transmit-side counterpart of the ldpc_dec receive chain. It accepts one information bit per cycle framed by sync_in and accumulates parity on the fly from a generator-row ROM. It emits a contiguous codeword, information bits first and then parity bits, framed by sync_out/valid_out. Supports the same two code rates as the decoder: 0 = 1/2, 1 = 3/4.

Parameters:
N_LEN, 96, codeword length in bits (fixed for both rates)
K_R12, 48, info bits at rate 1/2 (M = 48)
K_R34, 72, info bits at rate 3/4 (M = 24)
M_MAX, 48, parity register width (= N_LEN - K_R12)

Ports:
clk        input   1  system clock, all logic on rising edge
reset      input   1  synchronous, active-high reset
code_rate  input   1  0 = rate 1/2, 1 = rate 3/4; sampled only with accepted sync_in
data_in    input   1  information bit; valid for K cycles starting with the sync_in cycle
sync_in    input   1  one-cycle pulse marking the first info bit of a block
data_out   output  1  coded bit stream
sync_out   output  1  one-cycle pulse with the first coded bit
valid_out  output  1  high for exactly N_LEN consecutive cycles per codeword
busy       output  1  encoder owns a block (info collection or parity shift-out)
sync_err   output  1  one-cycle pulse: sync_in arrived while the block could not accept it

Behaviour:
- Reset: state IDLE; data_out, sync_out, valid_out, busy, sync_err = 0; counter, parity register and latched rate cleared. Reset during a block discards the block; no partial output follows.
- FSM: IDLE -> INFO on accepted sync_in; INFO -> PARITY after info bit K-1; PARITY -> IDLE after parity bit M-1, or PARITY -> INFO if sync_in is accepted in that same cycle.
- Acceptance: sync_in is accepted in IDLE, or in PARITY while the counter is at M-1 (gapless back-to-back). Any other sync_in is ignored and pulses sync_err on the next cycle. Ignored pulses do not disturb the current block.
- The accepted sync_in cycle is info index 0. The rate is latched then; K and M derive from the latched rate only.
- Parity accumulation: p_next = p XOR (data_in ? G[rate][i] : 0), where i is the info index (0..K-1) and G rows are M_MAX bits wide. Rate 3/4 uses bits [23:0] only, with upper bits forced 0. p clears on each accepted sync_in: the first row XORs into zero, not into the previous p.
- Output timing, latency 1: info bit i appears on data_out one cycle after it is sampled (output cycles 1..K). Parity bit j appears at output cycle K+1+j, LSB first (p[0] first), shifted from the register. Output is contiguous with no gap.
- sync_out is high with output cycle 1. valid_out is high for output cycles 1..N_LEN. data_out is 0 whenever valid_out is 0.
- busy is high from the cycle after accepted sync_in through the cycle carrying the last parity bit. It stays high across a gapless back-to-back boundary.
- Counter: 7 bits. Counts 0..K-1 in INFO and 0..M-1 in PARITY, and clears on each state change.

Decomposition:
- Package ldpc_enc_pkg: rate encoding constants (RATE_12 = 0, RATE_34 = 1), N_LEN/K/M constants, state enum (IDLE, INFO, PARITY), and the generator row tables as constant arrays.
- One sub-module, ldpc_enc_grom: combinational/registered-free lookup of (rate, index) -> M_MAX-bit row. It keeps ROM contents separate from control and lets the tables be regenerated.

Test Plan:
1. Rate 1/2, 48 zero info bits -> 96 valid_out cycles, all data_out = 0, sync_out at output cycle 1, busy falls after cycle 96.
2. Rate 1/2, single 1 at info index 0 -> data_out bit 1 = 1, bits 2..48 = 0, parity bits 49..96 equal G[0][0] row LSB first.
3. Rate 3/4, random 72 bits -> 72 info bits echoed, then 24 parity bits matching the golden model (XOR of selected rows). G[1] bits [47:24] never appear.
4. Back-to-back: second sync_in during the last parity cycle -> second sync_out exactly 1 cycle after last bit of first codeword, valid_out never drops, busy stays 1, sync_err stays 0.
5. sync_in at info index 10 of a rate-1/2 block -> sync_err pulse next cycle; the first codeword completes unchanged (96 bits, correct parity).
6. reset asserted at info index 20 -> next cycle all outputs 0, state IDLE; a new sync_in then yields a clean codeword with no stale parity contribution.
